// File: rtl/plugboard_stage.sv
// plugboard_stage
//   Keyboard-side front end of the Enigma datapath, feeding rotor_1.
//   Accepts one key code per valid/ready handshake, maps it through the
//   programmable plugboard swap table, tags it with the running press index
//   (0..25, wrapping) and presents the result through a one-deep registered
//   valid/ready output. A CLEAR walk restores the identity map one entry per
//   cycle.
//
// Ports
//   clk, rst                    rising-edge clock, async active-high reset
//   key_valid/key_code/key_ready   key input handshake (codes 0..25 legal)
//   cfg_wr, cfg_a, cfg_b        program swap pair cfg_a <-> cfg_b
//   cfg_clear                   start the identity-restore walk
//   cfg_busy                    high while the walk runs
//   cfg_err                     one-cycle pulse for a rejected cfg_wr
//   pair_count                  number of programmed pairs
//   plug_board_out              swapped letter to rotor_1
//   plugboard_presstime         press index of that letter
//   out_valid/out_ready         output handshake
module plugboard_stage #(
  parameter int MAX_PAIRS   = 10,
  parameter int NUM_LETTERS = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  output logic       key_ready,
  input  logic       cfg_wr,
  input  logic [4:0] cfg_a,
  input  logic [4:0] cfg_b,
  input  logic       cfg_clear,
  output logic       cfg_busy,
  output logic       cfg_err,
  output logic [3:0] pair_count,
  output logic [4:0] plug_board_out,
  output logic [4:0] plugboard_presstime,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam logic [4:0] LIMIT    = 5'(NUM_LETTERS);
  localparam logic [4:0] LAST     = 5'(NUM_LETTERS - 1);
  localparam logic [3:0] PAIR_MAX = 4'(MAX_PAIRS);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state, state_next;
  logic [4:0] map [NUM_LETTERS];
  logic [4:0] clr_idx;
  logic [4:0] counter;

  logic       in_idle;
  logic       clear_start;
  logic       wr_req;
  logic       a_legal, b_legal;
  logic [4:0] map_a, map_b;
  logic       wr_ok, wr_bad;
  logic       key_fire, key_take;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, request arbitration and handshake outputs
  always_comb begin
    state_next  = state;
    in_idle     = (state == IDLE);
    cfg_busy    = (state == CLEAR);
    clear_start = 1'b0;
    wr_req      = 1'b0;
    a_legal     = (cfg_a < LIMIT);
    b_legal     = (cfg_b < LIMIT);
    // Out-of-range codes never index the table; they fail the checks anyway.
    map_a       = a_legal ? map[cfg_a] : cfg_a;
    map_b       = b_legal ? map[cfg_b] : cfg_b;
    wr_ok       = 1'b0;
    wr_bad      = 1'b0;
    key_ready   = 1'b0;
    key_fire    = 1'b0;
    key_take    = 1'b0;

    if (state == IDLE) begin
      if (cfg_clear) state_next = CLEAR;
    end else begin
      if (clr_idx == LAST) state_next = IDLE;
    end

    // Priority in IDLE: cfg_clear > cfg_wr > key
    clear_start = in_idle && cfg_clear;
    wr_req      = in_idle && !cfg_clear && cfg_wr;
    wr_ok       = wr_req && a_legal && b_legal && (cfg_a != cfg_b) &&
                  (map_a == cfg_a) && (map_b == cfg_b) && (pair_count != PAIR_MAX);
    wr_bad      = wr_req && !wr_ok;
    key_ready   = in_idle && !cfg_clear && !cfg_wr && (!out_valid || out_ready);
    key_fire    = key_valid && key_ready;
    key_take    = key_fire && (key_code < LIMIT);
  end

  // Swap table; CLEAR and cfg_wr never coincide, keys only read it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_LETTERS; i++) map[i] <= 5'(i);
    end else if (state == CLEAR) begin
      map[clr_idx] <= clr_idx;
    end else if (wr_ok) begin
      map[cfg_a] <= cfg_b;
      map[cfg_b] <= cfg_a;
    end
  end

  // Walk index, pair count, error pulse, press counter and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_idx             <= '0;
      pair_count          <= '0;
      cfg_err             <= 1'b0;
      counter             <= '0;
      out_valid           <= 1'b0;
      plug_board_out      <= '0;
      plugboard_presstime <= '0;
    end else begin
      cfg_err <= wr_bad;

      if (clear_start)          clr_idx <= '0;
      else if (state == CLEAR)  clr_idx <= (clr_idx == LAST) ? '0 : clr_idx + 5'd1;

      if (clear_start)  pair_count <= '0;
      else if (wr_ok)   pair_count <= pair_count + 4'd1;

      // Illegal codes are consumed without output; the valid flag still
      // drops because key_ready already guaranteed the slot was free.
      if (key_take) begin
        plug_board_out      <= map[key_code];
        plugboard_presstime <= counter;
        out_valid           <= 1'b1;
        counter             <= (counter == LAST) ? '0 : counter + 5'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_plugboard_stage.sv
// tb_plugboard_stage
//   Directed bench for plugboard_stage: key mapping, press index wrap,
//   cfg_wr acceptance/rejection, output back-pressure, CLEAR walk and
//   asynchronous reset mid-walk.
module tb_plugboard_stage;

  logic       clk;
  logic       rst;
  logic       key_valid;
  logic [4:0] key_code;
  logic       key_ready;
  logic       cfg_wr;
  logic [4:0] cfg_a;
  logic [4:0] cfg_b;
  logic       cfg_clear;
  logic       cfg_busy;
  logic       cfg_err;
  logic [3:0] pair_count;
  logic [4:0] plug_board_out;
  logic [4:0] plugboard_presstime;
  logic       out_valid;
  logic       out_ready;

  int compared = 0;
  int mismatched = 0;

  plugboard_stage #(.MAX_PAIRS(10), .NUM_LETTERS(26)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .key_valid           (key_valid),
    .key_code            (key_code),
    .key_ready           (key_ready),
    .cfg_wr              (cfg_wr),
    .cfg_a               (cfg_a),
    .cfg_b               (cfg_b),
    .cfg_clear           (cfg_clear),
    .cfg_busy            (cfg_busy),
    .cfg_err             (cfg_err),
    .pair_count          (pair_count),
    .plug_board_out      (plug_board_out),
    .plugboard_presstime (plugboard_presstime),
    .out_valid           (out_valid),
    .out_ready           (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] code);
    key_valid = 1'b1;
    key_code  = code;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic cfg(input logic [4:0] a, input logic [4:0] b);
    cfg_wr = 1'b1;
    cfg_a  = a;
    cfg_b  = b;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [4:0] letter, input logic [4:0] t);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(plug_board_out), 32'(letter));
    chk({tag, "_time"}, 32'(plugboard_presstime), 32'(t));
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic err_seen;
    rst = 1'b1; key_valid = 1'b0; key_code = '0; cfg_wr = 1'b0;
    cfg_a = '0; cfg_b = '0; cfg_clear = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(plug_board_out), 32'd0);
    chk("rst_time", 32'(plugboard_presstime), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    chk("rst_busy", 32'(cfg_busy), 32'd0);
    chk("rst_pairs", 32'(pair_count), 32'd0);
    chk("rst_kready", 32'(key_ready), 32'd1);

    // 1: identity map, press index 0,1,2
    press(5'd0);  chk_out("t1_a", 5'd0, 5'd0);
    press(5'd1);  chk_out("t1_b", 5'd1, 5'd1);
    press(5'd25); chk_out("t1_z", 5'd25, 5'd2);
    chk("t1_pairs", 32'(pair_count), 32'd0);

    // 2: a<->q, rejects leave the map alone
    cfg(5'd0, 5'd16);
    chk("t2_wr_err", 32'(cfg_err), 32'd0);
    chk("t2_pairs", 32'(pair_count), 32'd1);
    press(5'd0);  chk_out("t2_a", 5'd16, 5'd3);
    press(5'd16); chk_out("t2_q", 5'd0, 5'd4);
    press(5'd5);  chk_out("t2_f", 5'd5, 5'd5);
    cfg(5'd16, 5'd23);
    chk("t2_qx_err", 32'(cfg_err), 32'd1);
    tick();
    chk("t2_err_pulse", 32'(cfg_err), 32'd0);
    cfg(5'd5, 5'd5);
    chk("t2_same_err", 32'(cfg_err), 32'd1);
    cfg(5'd5, 5'd27);
    chk("t2_range_err", 32'(cfg_err), 32'd1);
    chk("t2_pairs_kept", 32'(pair_count), 32'd1);
    press(5'd16); chk_out("t2_q2", 5'd0, 5'd6);
    press(5'd23); chk_out("t2_x", 5'd23, 5'd7);

    // 3: press index wrap, illegal code consumed mid-stream
    do_reset();
    key_valid = 1'b1;
    for (int i = 0; i < 27; i++) begin
      if (i == 13) begin
        key_code = 5'd30;
        tick();
        chk("t3_illegal_valid", 32'(out_valid), 32'd0);
      end
      key_code = 5'd3;
      tick();
      chk_out($sformatf("t3_k%0d", i), 5'd3, 5'(i % 26));
    end
    key_valid = 1'b0;
    tick();
    chk("t3_drain", 32'(out_valid), 32'd0);

    // 4: back-pressure holds the output register
    out_ready = 1'b0;
    press(5'd7);
    chk_out("t4_first", 5'd7, 5'd1);
    key_valid = 1'b1;
    key_code  = 5'd8;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("t4_hold%0d", i), 5'd7, 5'd1);
      chk($sformatf("t4_kready%0d", i), 32'(key_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("t4_release_kready", 32'(key_ready), 32'd1);
    tick();
    chk_out("t4_next", 5'd8, 5'd2);
    key_valid = 1'b0;
    tick();
    chk("t4_drain", 32'(out_valid), 32'd0);

    // 5: fill the pair table, overflow reject, then CLEAR walk
    for (int i = 0; i < 10; i++) begin
      cfg(5'(2 * i), 5'(2 * i + 1));
      chk($sformatf("t5_wr%0d_err", i), 32'(cfg_err), 32'd0);
    end
    chk("t5_pairs_full", 32'(pair_count), 32'd10);
    cfg(5'd20, 5'd21);
    chk("t5_overflow_err", 32'(cfg_err), 32'd1);
    chk("t5_pairs_kept", 32'(pair_count), 32'd10);
    press(5'd2);
    chk_out("t5_swapped", 5'd3, 5'd3);
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    chk("t5_clear_pairs", 32'(pair_count), 32'd0);
    chk("t5_clear_kready", 32'(key_ready), 32'd0);
    // Keys and cfg_wr offered throughout the walk must be ignored
    key_valid = 1'b1; key_code = 5'd0;
    cfg_a = 5'd22; cfg_b = 5'd23;
    n = 0;
    err_seen = 1'b0;
    while (cfg_busy && n < 40) begin
      n++;
      cfg_wr = (n == 5);
      tick();
      if (cfg_err) err_seen = 1'b1;
    end
    key_valid = 1'b0;
    cfg_wr = 1'b0;
    chk("t5_busy_cycles", 32'(n), 32'd26);
    chk("t5_walk_no_out", 32'(out_valid), 32'd0);
    chk("t5_walk_no_err", 32'(err_seen), 32'd0);
    chk("t5_walk_pairs", 32'(pair_count), 32'd0);
    press(5'd0);  chk_out("t5_id0", 5'd0, 5'd4);
    press(5'd1);  chk_out("t5_id1", 5'd1, 5'd5);
    press(5'd19); chk_out("t5_id19", 5'd19, 5'd6);

    // 6: async reset mid-walk with a held output
    cfg(5'd20, 5'd24);
    chk("t6_wr_err", 32'(cfg_err), 32'd0);
    out_ready = 1'b0;
    press(5'd24);
    chk_out("t6_held", 5'd20, 5'd7);
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("t6_busy_c7", 32'(cfg_busy), 32'd1);
    chk("t6_valid_c7", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_data", 32'(plug_board_out), 32'd0);
    chk("t6_rst_time", 32'(plugboard_presstime), 32'd0);
    chk("t6_rst_busy", 32'(cfg_busy), 32'd0);
    chk("t6_rst_pairs", 32'(pair_count), 32'd0);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    press(5'd24); chk_out("t6_map_id", 5'd24, 5'd0);

    // cfg_clear beats cfg_wr in the same cycle
    cfg_wr = 1'b1; cfg_a = 5'd1; cfg_b = 5'd2; cfg_clear = 1'b1;
    tick();
    cfg_wr = 1'b0; cfg_clear = 1'b0;
    chk("t6_both_err", 32'(cfg_err), 32'd0);
    chk("t6_both_busy", 32'(cfg_busy), 32'd1);
    chk("t6_both_pairs", 32'(pair_count), 32'd0);
    n = 0;
    while (cfg_busy && n < 40) begin
      n++;
      tick();
    end
    chk("t6_both_cycles", 32'(n), 32'd26);
    press(5'd1); chk_out("t6_no_pair", 5'd1, 5'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
